// File: rtl/simd_inst_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module : simd_inst_pkg
// Brief  : Shared types and constants for the SIMD instruction receiver.
// Rev    : 1.0
// ============================================================================
package simd_inst_pkg;

  localparam int c_INST_BW = 32;
  localparam int c_OP_BW   = 4;
  localparam int c_REP_BW  = 8;
  localparam int c_ARG_BW  = 20;

  localparam logic [c_OP_BW-1:0] OP_FENCE = 4'hF;

  typedef struct packed {
    logic [c_OP_BW-1:0]  op;
    logic [c_REP_BW-1:0] rep;
    logic [c_ARG_BW-1:0] arg;
  } Inst_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FENCE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/simd_inst_receiver_if.sv
`default_nettype none
// ============================================================================
// Module : simd_inst_receiver_if
// Brief  : Instruction-in and lane-op-out rdy/ack channels of the receiver.
// Rev    : 1.0
// ============================================================================
interface simd_inst_receiver_if #(
  parameter int INST_BW = 32,
  parameter int OP_BW   = 4,
  parameter int REP_BW  = 8,
  parameter int ARG_BW  = 20
);
  logic               inst_rdy;
  logic               inst_ack;
  logic [INST_BW-1:0] i_inst;
  logic               alu_rdy;
  logic               alu_ack;
  logic [OP_BW-1:0]   o_op;
  logic [ARG_BW-1:0]  o_arg;
  logic [REP_BW-1:0]  o_iter;
  logic               o_last;

  // slave is the receiver's view; master is the producer/ALU environment
  modport slave (
    input  inst_rdy, i_inst, alu_ack,
    output inst_ack, alu_rdy, o_op, o_arg, o_iter, o_last
  );

  modport master (
    output inst_rdy, i_inst, alu_ack,
    input  inst_ack, alu_rdy, o_op, o_arg, o_iter, o_last
  );
endinterface
`default_nettype wire

// File: rtl/simd_inst_receiver_fifo.sv
`default_nettype none
// ============================================================================
// Module : simd_inst_fifo
// Brief  : DEPTH x WIDTH register FIFO, extra-MSB pointers, async reset.
// Rev    : 1.0
// ============================================================================
module simd_inst_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  wire logic             i_clk,
  input  wire logic             i_rst,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_din,
  input  wire logic             i_pop,
  output logic      [WIDTH-1:0] o_dout,
  output logic                  o_full,
  output logic                  o_empty
);
  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW:0]    r_wptr;
  logic [c_AW:0]    r_rptr;
  logic             w_wr;
  logic             w_rd;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                   (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
  assign w_wr    = i_push && !o_full;
  assign w_rd    = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rptr[c_AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset: empty pointers make stale words unreachable.
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr[c_AW-1:0]] <= i_din;
  end

endmodule
`default_nettype wire

// File: rtl/simd_inst_receiver.sv
`default_nettype none
// ============================================================================
// Module : simd_inst_receiver
// Brief  : Buffers SIMD instructions and expands each into rep+1 lane ops.
// Rev    : 1.0
// ============================================================================
module simd_inst_receiver
  import simd_inst_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int INST_BW = 32,
  parameter int OP_BW   = 4,
  parameter int REP_BW  = 8,
  parameter int ARG_BW  = 20
) (
  input  wire logic           i_clk,
  input  wire logic           i_rst,
  simd_inst_receiver_if.slave bus,
  input  wire logic           i_alu_idle,
  output logic                o_busy
);
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_push;
  logic               w_iter_inc;
  logic               w_last;
  logic [INST_BW-1:0] w_head;
  logic [OP_BW-1:0]   w_head_op;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [OP_BW-1:0]   r_op;
  logic [REP_BW-1:0]  r_rep;
  logic [ARG_BW-1:0]  r_arg;
  logic [REP_BW-1:0]  r_iter;

  // A full FIFO refuses the word even if a pop happens in the same cycle.
  assign w_push       = bus.inst_rdy && !w_full && !i_rst;
  assign bus.inst_ack = w_push;

  simd_inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INST_BW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_din   (bus.i_inst),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head_op = w_head[INST_BW-1 -: OP_BW];
  assign w_last    = (r_iter == r_rep);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_iter_inc  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = (w_head_op == OP_FENCE) ? FENCE : ISSUE;
        end
      end
      ISSUE: begin
        if (bus.alu_ack) begin
          if (w_last) w_state_nxt = IDLE;
          else        w_iter_inc  = 1'b1;
        end
      end
      FENCE: begin
        if (i_alu_idle) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_op   <= '0;
      r_rep  <= '0;
      r_arg  <= '0;
      r_iter <= '0;
    end else if (w_pop) begin
      r_op   <= w_head_op;
      r_rep  <= w_head[ARG_BW +: REP_BW];
      r_arg  <= w_head[ARG_BW-1:0];
      r_iter <= '0;
    end else if (w_iter_inc) begin
      r_iter <= r_iter + 1'b1;
    end
  end

  assign bus.alu_rdy = (r_state == ISSUE);
  assign bus.o_op    = r_op;
  assign bus.o_arg   = r_arg;
  assign bus.o_iter  = r_iter;
  assign bus.o_last  = (r_state == ISSUE) && w_last;
  assign o_busy      = !w_empty || (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_simd_inst_receiver.sv
`default_nettype none
// ============================================================================
// Module : tb_simd_inst_receiver
// Brief  : Directed self-checking bench for simd_inst_receiver.
// Rev    : 1.0
// ============================================================================
module tb_simd_inst_receiver;
  import simd_inst_pkg::*;

  typedef struct {
    logic [3:0]  op;
    logic [19:0] arg;
    logic [7:0]  iter;
    logic        last;
  } rec_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_alu_idle = 1'b0;
  logic o_busy;
  int   n_err = 0;
  int   n_chk = 0;
  rec_t q[$];

  simd_inst_receiver_if bus ();

  simd_inst_receiver u_dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .bus        (bus),
    .i_alu_idle (i_alu_idle),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [7:0] rep,
                                     input logic [19:0] arg);
    Inst_t t;
    t.op  = op;
    t.rep = rep;
    t.arg = arg;
    return t;
  endfunction

  task automatic push(input string tag, input logic [31:0] w, input logic exp_ack);
    bus.inst_rdy = 1'b1;
    bus.i_inst   = w;
    #1;
    chk(tag, {31'd0, bus.inst_ack}, {31'd0, exp_ack});
    tick();
    bus.inst_rdy = 1'b0;
  endtask

  // Acks every lane op until the receiver goes quiet; records what it saw.
  task automatic collect(input int max_cyc);
    q.delete();
    bus.alu_ack = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      #1;
      if (bus.alu_rdy) q.push_back('{bus.o_op, bus.o_arg, bus.o_iter, bus.o_last});
      else if (!o_busy) break;
      tick();
    end
    chk("drain_done", {31'd0, o_busy}, 32'd0);
    bus.alu_ack = 1'b0;
  endtask

  initial begin
    int n;
    int e;
    int bad;
    logic ph;

    bus.inst_rdy = 1'b1;
    bus.i_inst   = 32'hDEAD_BEEF;
    bus.alu_ack  = 1'b0;
    #2;
    chk("rst_alu_rdy", {31'd0, bus.alu_rdy}, 32'd0);
    chk("rst_inst_ack", {31'd0, bus.inst_ack}, 32'd0);
    chk("rst_op", {28'd0, bus.o_op}, 32'd0);
    chk("rst_arg", {12'd0, bus.o_arg}, 32'd0);
    chk("rst_iter", {24'd0, bus.o_iter}, 32'd0);
    chk("rst_last", {31'd0, bus.o_last}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    tick();
    tick();
    i_rst        = 1'b0;
    bus.inst_rdy = 1'b0;

    // single op, rep=0, ack tied high
    bus.alu_ack = 1'b1;
    push("t1_ack", mk(4'h3, 8'd0, 20'h12345), 1'b1);
    chk("t1_pop_gap_rdy", {31'd0, bus.alu_rdy}, 32'd0);
    chk("t1_pop_gap_busy", {31'd0, o_busy}, 32'd1);
    tick();
    chk("t1_rdy", {31'd0, bus.alu_rdy}, 32'd1);
    chk("t1_op", {28'd0, bus.o_op}, 32'd3);
    chk("t1_arg", {12'd0, bus.o_arg}, 32'h12345);
    chk("t1_iter", {24'd0, bus.o_iter}, 32'd0);
    chk("t1_last", {31'd0, bus.o_last}, 32'd1);
    tick();
    chk("t1_done_rdy", {31'd0, bus.alu_rdy}, 32'd0);
    chk("t1_done_busy", {31'd0, o_busy}, 32'd0);
    bus.alu_ack = 1'b0;

    // rep=3 with alternating ack: data must hold through stall cycles
    push("t2_ack", mk(4'h2, 8'd3, 20'hBEEF2), 1'b1);
    tick();
    chk("t2_first_rdy", {31'd0, bus.alu_rdy}, 32'd1);
    e  = 0;
    ph = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus.alu_ack = ph;
      ph = ~ph;
      #1;
      chk("t2_rdy", {31'd0, bus.alu_rdy}, {31'd0, e < 4});
      if (e < 4) begin
        chk("t2_op", {28'd0, bus.o_op}, 32'd2);
        chk("t2_arg", {12'd0, bus.o_arg}, 32'hBEEF2);
        chk("t2_iter", {24'd0, bus.o_iter}, e);
        chk("t2_last", {31'd0, bus.o_last}, {31'd0, e == 3});
      end
      if (bus.alu_rdy && bus.alu_ack) e++;
      tick();
    end
    chk("t2_count", e, 32'd4);
    bus.alu_ack = 1'b0;

    // FIFO full: A sits in ISSUE, B1..B4 fill the FIFO, B5 waits for a pop
    push("t3_a_ack", mk(4'hA, 8'd0, 20'h0A0A0), 1'b1);
    tick();
    chk("t3_a_rdy", {31'd0, bus.alu_rdy}, 32'd1);
    for (int i = 1; i <= 4; i++)
      push("t3_fill_ack", mk(4'(i), 8'd0, 20'(i * 16'h1111)), 1'b1);
    bus.inst_rdy = 1'b1;
    bus.i_inst   = mk(4'd5, 8'd0, 20'h55550);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t3_full_ack", {31'd0, bus.inst_ack}, 32'd0);
      chk("t3_hold_op", {28'd0, bus.o_op}, 32'hA);
      tick();
    end
    bus.alu_ack = 1'b1;
    #1;
    chk("t3_full_ack_on_done", {31'd0, bus.inst_ack}, 32'd0);
    tick();
    bus.alu_ack = 1'b0;
    #1;
    chk("t3_idle_ack", {31'd0, bus.inst_ack}, 32'd0);
    chk("t3_idle_rdy", {31'd0, bus.alu_rdy}, 32'd0);
    tick();
    chk("t3_freed_ack", {31'd0, bus.inst_ack}, 32'd1);
    tick();
    bus.inst_rdy = 1'b0;
    collect(100);
    chk("t3_n_ops", q.size(), 32'd5);
    for (int i = 0; i < q.size(); i++) begin
      chk("t3_order_op", {28'd0, q[i].op}, i + 1);
      chk("t3_order_arg", {12'd0, q[i].arg}, (i < 4) ? (i + 1) * 32'h1111 : 32'h55550);
    end

    // FENCE stalls issue while the ALU reports busy
    i_alu_idle = 1'b0;
    push("t4_i1_ack", mk(4'h1, 8'd1, 20'h00111), 1'b1);
    push("t4_fence_ack", mk(4'hF, 8'd0, 20'h0), 1'b1);
    push("t4_i2_ack", mk(4'h1, 8'd1, 20'h00222), 1'b1);
    bus.alu_ack = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.alu_rdy) n++;
      if (c >= 10) chk("t4_fence_rdy", {31'd0, bus.alu_rdy}, 32'd0);
      tick();
    end
    chk("t4_pre_fence_ops", n, 32'd2);
    chk("t4_fence_busy", {31'd0, o_busy}, 32'd1);
    i_alu_idle = 1'b1;
    collect(20);
    chk("t4_post_n", q.size(), 32'd2);
    chk("t4_post_arg", {12'd0, q[0].arg}, 32'h00222);
    chk("t4_post_iter0", {24'd0, q[0].iter}, 32'd0);
    chk("t4_post_last0", {31'd0, q[0].last}, 32'd0);
    chk("t4_post_iter1", {24'd0, q[1].iter}, 32'd1);
    chk("t4_post_last1", {31'd0, q[1].last}, 32'd1);

    // rep=255 yields 256 lane ops with no wrap
    push("t5_ack", mk(4'h6, 8'd255, 20'hABCDE), 1'b1);
    collect(600);
    chk("t5_n", q.size(), 32'd256);
    bad = 0;
    foreach (q[i])
      if (q[i].iter != 8'(i) || q[i].last != (i == 255) || q[i].op != 4'h6) bad++;
    chk("t5_seq_bad", bad, 32'd0);
    if (q.size() == 256) begin
      chk("t5_last_iter", {24'd0, q[255].iter}, 32'd255);
      chk("t5_last_flag", {31'd0, q[255].last}, 32'd1);
    end

    // reset mid-ISSUE drops the instruction and the queue
    push("t6_a_ack", mk(4'h7, 8'd7, 20'h77777), 1'b1);
    push("t6_b_ack", mk(4'h8, 8'd0, 20'h88888), 1'b1);
    push("t6_c_ack", mk(4'h9, 8'd0, 20'h99999), 1'b1);
    bus.alu_ack = 1'b1;
    tick();
    tick();
    chk("t6_pre_iter", {24'd0, bus.o_iter}, 32'd2);
    chk("t6_pre_rdy", {31'd0, bus.alu_rdy}, 32'd1);
    #2;
    i_rst = 1'b1;
    #1;
    chk("t6_rst_rdy", {31'd0, bus.alu_rdy}, 32'd0);
    chk("t6_rst_busy", {31'd0, o_busy}, 32'd0);
    chk("t6_rst_iter", {24'd0, bus.o_iter}, 32'd0);
    tick();
    i_rst = 1'b0;
    n = 0;
    for (int c = 0; c < 15; c++) begin
      #1;
      if (bus.alu_rdy) n++;
      tick();
    end
    chk("t6_no_ops_after_rst", n, 32'd0);
    bus.alu_ack = 1'b0;
    push("t6_new_ack", mk(4'h5, 8'd0, 20'h55555), 1'b1);
    collect(20);
    chk("t6_new_n", q.size(), 32'd1);
    chk("t6_new_op", {28'd0, q[0].op}, 32'd5);
    chk("t6_new_arg", {12'd0, q[0].arg}, 32'h55555);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
